dcpu_intc: RTL and testbench
============================

DCPU_INTC -- requirements
Module: dcpu_intc

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (legal 1..16).
REQ-002 SHALL have parameter BASE_ADDR, default 16'hFF00, base of the 4-word register window (bits [1:0] ignored).
REQ-003 SHALL have port i_clk  input  1  sole clock, all flops on rising edge.
REQ-004 SHALL have port i_reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port i_addr  input  16  CPU bus address.
REQ-006 SHALL have port i_dat  input  16  CPU write data.
REQ-007 SHALL have port o_dat  output  16  read data, valid while o_ack=1, else 0.
REQ-008 SHALL have port i_we  input  1  write strobe, qualified by i_cs.
REQ-009 SHALL have port i_cs  input  1  bus cycle request, held by the CPU until acked.
REQ-010 SHALL have port o_ack  output  1  one-cycle access acknowledge.
REQ-011 SHALL have port i_irq  input  NUM_SRC  asynchronous interrupt request lines.
REQ-012 SHALL have port o_int  output  1  registered interrupt request to the CPU i_int input.

Function
REQ-013 SHALL decode a hit when i_cs=1, i_addr[15:2]=BASE_ADDR[15:2], and the bus FSM is in IDLE; a non-hit is ignored with o_ack held at 0.
REQ-014 SHALL use bus FSM IDLE->ACK on hit; ACK->IDLE unconditionally; o_ack=1 only in ACK, so exactly one ack per access, even if i_cs stays high.
REQ-015 SHALL register read data and commit writes on the IDLE->ACK edge, giving a fixed one-cycle access latency.
REQ-016 SHALL map offset 0 to PENDING: reads return pending bits; a write of 1 clears the bit (W1C) and a write of 0 has no effect.
REQ-017 SHALL map offset 1 to MASK: read/write, 1 enables the source.
REQ-018 SHALL map offset 2 to VECTOR: read-only; returns the index of the lowest-numbered pending&mask bit, or 16'hFFFF if none; writes are ignored.
REQ-019 SHALL map offset 3 to EDGE: read/write, 1 makes the source rising-edge, 0 makes it level.
REQ-020 SHALL read all bits at or above NUM_SRC as 0 and ignore writes to them.
REQ-021 For an edge source, SHALL set pending on a 0->1 transition of the sampled input; pending stays set until W1C.
REQ-022 For a level source, SHALL set pending on every cycle the sampled input is 1; a W1C while the input is high has no lasting effect.
REQ-023 SHALL give set priority over clear when a set event and a W1C hit the same bit in the same cycle.
REQ-024 SHALL register o_int = |(pending & mask) one cycle after pending or mask changes.
REQ-025 SHALL treat a MASK change as not altering pending; masked sources still latch.

Reset
REQ-026 SHALL asynchronously force PENDING, MASK, EDGE, the sync/edge flops, bus FSM=IDLE, o_ack=0, o_dat=0, o_int=0 when i_reset_n=0.
REQ-027 SHALL abort an in-flight ACK on reset with no write committed; the first hit after release acks normally.

Configuration
REQ-028 SHALL, with macro DCPU_INTC_SYNC_EN defined, pass each i_irq bit through a 2-flop synchronizer before edge/level detection, giving 3 cycles from i_irq to pending.
REQ-029 SHALL, without DCPU_INTC_SYNC_EN, sample i_irq directly into the edge-detect flop, giving 1 cycle from i_irq to pending.

Structure
REQ-030 SHALL place the register offsets (REG_PENDING=0, REG_MASK=1, REG_VECTOR=2, REG_EDGE=3), the bus FSM state encoding, and VECTOR_NONE=16'hFFFF in shared package dcpu_pkg.
REQ-031 SHALL implement the per-source synchronizer plus edge detector as sub-module dcpu_intc_sync, instantiated NUM_SRC times.
REQ-032 SHALL implement the priority encoder for VECTOR inline as combinational logic in dcpu_intc.

Verification
REQ-033 Bench SHALL cover: write MASK=0x0005 at 0xFF01, then read it back -> o_ack high exactly one cycle after i_cs, o_dat=0x0005, and no second ack while i_cs is held.
REQ-034 Bench SHALL cover: EDGE=0x01, MASK=0x01, 1-cycle pulse on i_irq[0] -> PENDING=0x0001, o_int=1 (3+1 cycles with SYNC_EN), VECTOR=0; W1C 0x0001 -> o_int=0.
REQ-035 Bench SHALL cover: level source 3 held high, MASK=0x08, W1C 0x0008 -> PENDING reads 0x0008 again and o_int stays 1; drop i_irq[3] and W1C -> o_int=0.
REQ-036 Bench SHALL cover: sources 2 and 5 pending, MASK=0x24 -> VECTOR=2; W1C bit 2 -> VECTOR=5; clear all -> VECTOR=0xFFFF.
REQ-037 Bench SHALL cover: edge on source 1 in the same cycle as W1C 0x0002 -> bit 1 remains pending.
REQ-038 Bench SHALL cover: assert i_reset_n=0 during ACK of a MASK write of 0x00FF -> o_ack drops immediately, and after release MASK reads 0x0000.

Source files
------------

// File: rtl/dcpu_pkg.sv
// Shared definitions for the DCPU interrupt controller: register offsets,
// bus FSM encoding and the "no pending interrupt" vector value.
package dcpu_pkg;

    typedef enum logic [1:0] {
        REG_PENDING = 2'd0,
        REG_MASK    = 2'd1,
        REG_VECTOR  = 2'd2,
        REG_EDGE    = 2'd3
    } reg_e;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    localparam logic [15:0] VECTOR_NONE = 16'hFFFF;

endpackage

// File: rtl/dcpu_intc_sync.sv
// Per-source input conditioning: optional 2-flop synchronizer (DCPU_INTC_SYNC_EN)
// followed by edge/level detection producing a one-cycle-wide set request.
module dcpu_intc_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic edge_mode,
    output logic set
);

    logic sampled;
    logic prev;

`ifdef DCPU_INTC_SYNC_EN
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b0;
            sampled <= 1'b0;
            prev    <= 1'b0;
        end else begin
            meta    <= irq;
            sampled <= meta;
            prev    <= sampled;
        end
    end
`else
    // Unsynchronized build: the raw line feeds detection, so pending follows one edge later.
    assign sampled = irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= irq;
        end
    end
`endif

    assign set = edge_mode ? (sampled & ~prev) : sampled;

endmodule

// File: rtl/dcpu_intc.sv
// DCPU interrupt controller: PENDING/MASK/VECTOR/EDGE register window on a
// one-cycle-ack CPU bus. Define DCPU_INTC_SYNC_EN to synchronize i_irq.
module dcpu_intc
    import dcpu_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [15:0]        i_addr,
    input  logic [15:0]        i_dat,
    output logic [15:0]        o_dat,
    input  logic               i_we,
    input  logic               i_cs,
    output logic               o_ack,
    input  logic [NUM_SRC-1:0] i_irq,
    output logic               o_int
);

    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    bus_state_e        state_q;
    bus_state_e        state_d;
    logic              hit;
    reg_e              offset;
    logic [15:0]       pending_q;
    logic [15:0]       mask_q;
    logic [15:0]       edge_q;
    logic [15:0]       wdat;
    logic [15:0]       w1c;
    logic [15:0]       set_vec;
    logic [NUM_SRC-1:0] set_src;
    logic [15:0]       active;
    logic [15:0]       vector;
    logic [15:0]       rdata;

    assign offset = reg_e'(i_addr[1:0]);
    assign hit    = i_cs && (i_addr[15:2] == BASE_ADDR[15:2]) && (state_q == BUS_IDLE);
    assign wdat   = i_dat & SRC_MASK;
    assign w1c    = (hit && i_we && offset == REG_PENDING) ? wdat : '0;
    assign active = pending_q & mask_q;
    assign o_ack  = (state_q == BUS_ACK);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        dcpu_intc_sync u_sync (
            .clk       (i_clk),
            .rst_n     (i_reset_n),
            .irq       (i_irq[g]),
            .edge_mode (edge_q[g]),
            .set       (set_src[g])
        );
    end

    always_comb begin
        set_vec                = '0;
        set_vec[NUM_SRC-1:0]   = set_src;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (hit) state_d = BUS_ACK;
            BUS_ACK:  state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan from the top so the lowest-numbered active source is the last to win.
    always_comb begin
        vector = VECTOR_NONE;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (active[NUM_SRC - 1 - i]) begin
                vector = 16'(NUM_SRC - 1 - i);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            REG_PENDING: rdata = pending_q;
            REG_MASK:    rdata = mask_q;
            REG_VECTOR:  rdata = vector;
            REG_EDGE:    rdata = edge_q;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending_q <= '0;
            mask_q    <= '0;
            edge_q    <= '0;
            o_dat     <= '0;
            o_int     <= 1'b0;
        end else begin
            pending_q <= ((pending_q & ~w1c) | set_vec) & SRC_MASK;
            o_int     <= |active;
            o_dat     <= hit ? rdata : '0;
            if (hit && i_we && offset == REG_MASK) begin
                mask_q <= wdat;
            end
            if (hit && i_we && offset == REG_EDGE) begin
                edge_q <= wdat;
            end
        end
    end

endmodule

// File: tb/tb_dcpu_intc.sv
// Self-checking bench for dcpu_intc: directed scenarios plus randomized bus/irq
// traffic checked against a cycle-level behavioural model of the register set.
module tb_dcpu_intc;

    localparam int          NS   = 8;
    localparam logic [15:0] BASE = 16'hFF00;
    localparam logic [15:0] VM   = 16'h00FF;
`ifdef DCPU_INTC_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   addr;
    logic [15:0]   wdat;
    logic [15:0]   rdat;
    logic          we;
    logic          cs;
    logic          ack;
    logic [NS-1:0] irq;
    logic          intr;

    int passes = 0;
    int total  = 0;

    logic [15:0] m_pend, m_mask, m_edge, m_prev;
    logic [15:0] hist [2];
    logic        m_int;
    logic        bw_en;
    logic [1:0]  bw_off;
    logic [15:0] bw_dat;
    logic [15:0] rd;

    dcpu_intc #(.NUM_SRC(NS), .BASE_ADDR(BASE)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_addr    (addr),
        .i_dat     (wdat),
        .o_dat     (rdat),
        .i_we      (we),
        .i_cs      (cs),
        .o_ack     (ack),
        .i_irq     (irq),
        .o_int     (intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_edge = '0; m_prev = '0; m_int = 1'b0;
        hist[0] = '0; hist[1] = '0; bw_en = 1'b0; bw_off = '0; bw_dat = '0;
    endtask

    function automatic logic [15:0] m_read(input logic [1:0] off);
        case (off)
            2'd0: return m_pend;
            2'd1: return m_mask;
            2'd2: begin
                for (int i = 0; i < NS; i++)
                    if (m_pend[i] && m_mask[i]) return 16'(i);
                return 16'hFFFF;
            end
            default: return m_edge;
        endcase
    endfunction

    // One clock: model reacts to the inputs present at the rising edge, outputs checked at the falling edge.
    task automatic tick();
        logic [15:0] eff, setv, clr;
        @(posedge clk);
        eff = (LAT == 1) ? 16'(irq) : hist[1];
        hist[1] = hist[0];
        hist[0] = 16'(irq);
        setv = '0;
        for (int i = 0; i < NS; i++)
            setv[i] = m_edge[i] ? (eff[i] & ~m_prev[i]) : eff[i];
        m_int = |(m_pend & m_mask);
        clr = (bw_en && bw_off == 2'd0) ? (bw_dat & VM) : '0;
        m_pend = ((m_pend & ~clr) | setv) & VM;
        if (bw_en && bw_off == 2'd1) m_mask = bw_dat & VM;
        if (bw_en && bw_off == 2'd3) m_edge = bw_dat & VM;
        m_prev = eff;
        bw_en = 1'b0;
        @(negedge clk);
        check("o_int", 16'(intr), 16'(m_int));
    endtask

    task automatic bus(input logic w, input logic [1:0] off, input logic [15:0] d, output logic [15:0] r);
        logic [15:0] exp;
        cs = 1'b1; we = w; addr = BASE | 16'(off); wdat = d;
        exp = m_read(off);
        bw_en = w; bw_off = off; bw_dat = d;
        tick();
        check("ack_first", 16'(ack), 16'h1);
        if (!w) check("rdata", rdat, exp);
        r = rdat;
        tick();
        check("ack_held", 16'(ack), 16'h0);
        check("dat_idle", rdat, 16'h0);
        cs = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; wdat = '0; we = 1'b0; cs = 1'b0; irq = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ack", 16'(ack), 16'h0);
        check("rst_dat", rdat, 16'h0);
        check("rst_int", 16'(intr), 16'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Miss: wrong window must not ack
        cs = 1'b1; we = 1'b0; addr = 16'hFE01;
        tick();
        check("miss_ack", 16'(ack), 16'h0);
        cs = 1'b0;

        // Mask write/readback with single ack
        bus(1'b1, 2'd1, 16'h0005, rd);
        bus(1'b0, 2'd1, 16'h0000, rd);
        check("mask_rb", rd, 16'h0005);

        // Edge source 0 single pulse
        bus(1'b1, 2'd3, 16'h0001, rd);
        bus(1'b1, 2'd1, 16'h0001, rd);
        irq = 8'h01;
        tick();
        irq = '0;
        repeat (LAT) tick();
        check("edge_int", 16'(intr), 16'h1);
        bus(1'b0, 2'd0, 16'h0, rd);
        check("edge_pend", rd, 16'h0001);
        bus(1'b0, 2'd2, 16'h0, rd);
        check("edge_vec", rd, 16'h0000);
        bus(1'b1, 2'd0, 16'h0001, rd);
        tick();
        check("edge_clr_int", 16'(intr), 16'h0);

        // Level source 3 held high survives W1C
        bus(1'b1, 2'd3, 16'h0000, rd);
        bus(1'b1, 2'd1, 16'h0008, rd);
        irq = 8'h08;
        repeat (LAT + 1) tick();
        bus(1'b1, 2'd0, 16'h0008, rd);
        bus(1'b0, 2'd0, 16'h0, rd);
        check("lvl_pend", rd, 16'h0008);
        check("lvl_int", 16'(intr), 16'h1);
        irq = '0;
        repeat (LAT + 1) tick();
        bus(1'b1, 2'd0, 16'h0008, rd);
        tick();
        check("lvl_clr_int", 16'(intr), 16'h0);

        // Vector priority with sources 2 and 5
        bus(1'b1, 2'd3, 16'h0024, rd);
        irq = 8'h24;
        tick();
        irq = '0;
        repeat (LAT + 1) tick();
        bus(1'b1, 2'd1, 16'h0024, rd);
        bus(1'b0, 2'd2, 16'h0, rd);
        check("vec_2", rd, 16'h0002);
        bus(1'b1, 2'd0, 16'h0004, rd);
        bus(1'b0, 2'd2, 16'h0, rd);
        check("vec_5", rd, 16'h0005);
        bus(1'b1, 2'd0, 16'h00FF, rd);
        bus(1'b0, 2'd2, 16'h0, rd);
        check("vec_none", rd, 16'hFFFF);

        // Set beats W1C on the same edge
        bus(1'b1, 2'd3, 16'h0002, rd);
        bus(1'b1, 2'd1, 16'h0002, rd);
        irq = 8'h02;
        tick();
        irq = '0;
        repeat (LAT + 2) tick();
        irq = 8'h02;
        repeat (LAT - 1) tick();
        bus(1'b1, 2'd0, 16'h0002, rd);
        irq = '0;
        bus(1'b0, 2'd0, 16'h0, rd);
        check("set_wins", rd & 16'h0002, 16'h0002);
        bus(1'b1, 2'd0, 16'h00FF, rd);
        repeat (LAT + 1) tick();

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  off;
            logic        w;
            irq = NS'($urandom);
            off = 2'($urandom_range(0, 3));
            w   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tick();
            else bus(w, off, 16'($urandom), rd);
        end
        irq = '0;
        repeat (LAT + 1) tick();

        // Reset during ACK of MASK write
        cs = 1'b1; we = 1'b1; addr = BASE | 16'h1; wdat = 16'h00FF;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_ack", 16'(ack), 16'h1);
        rst_n = 1'b0;
        #1;
        check("rst_abort_ack", 16'(ack), 16'h0);
        check("rst_abort_int", 16'(intr), 16'h0);
        cs = 1'b0; we = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus(1'b0, 2'd1, 16'h0, rd);
        check("mask_after_rst", rd, 16'h0000);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
